// File: rtl/mpi_ahb3_slave_if.sv
// AHB3-Lite slave front-end for the MPI message buffer: one AHB beat becomes one buffer access.
// Optional ACCESS timeout enabled by defining MPI_AHB3_TIMEOUT_EN.
module mpi_ahb3_slave_if #(
  parameter int unsigned PLEN    = 32,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP,
  output logic [31:0]     bus_addr,
  output logic            bus_we,
  output logic            bus_en,
  output logic [31:0]     bus_data_in,
  input  logic [31:0]     bus_data_out,
  input  logic            bus_ack,
  input  logic            bus_err
);

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_RESP   = 3'd2,
    S_ERR1   = 3'd3,
    S_ERR2   = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   accept, bad_xfer, timeout_hit;
  logic   capture, load_rdata;
  logic   ready_nxt, resp_nxt, en_nxt;
  logic   unused_ok;

  assign bus_data_in = 32'(HWDATA);
  assign accept      = HSEL & HREADY & HTRANS[1];
  assign bad_xfer    = (HSIZE != HSIZE_WORD) | (HADDR[1:0] != 2'b00);
  assign unused_ok   = &{1'b0, HBURST, HPROT, HMASTLOCK, HTRANS[0], 32'(TIMEOUT)};

`ifdef MPI_AHB3_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt;

  // Counts stalled ACCESS cycles; held at zero outside ACCESS so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state != S_ACCESS) begin
      to_cnt <= '0;
    end else if (!bus_ack && !bus_err) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == S_ACCESS) && (to_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state; a new address phase is only taken where HREADYOUT is high.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    load_rdata = 1'b0;
    ready_nxt  = 1'b1;
    resp_nxt   = 1'b0;
    en_nxt     = 1'b0;
    unique case (state)
      S_IDLE, S_RESP, S_ERR2: begin
        state_nxt = S_IDLE;
        if (accept) begin
          capture   = 1'b1;
          state_nxt = bad_xfer ? S_ERR1 : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (bus_err) begin
          state_nxt = S_ERR1;
        end else if (bus_ack) begin
          state_nxt  = S_RESP;
          load_rdata = !bus_we;
        end else if (timeout_hit) begin
          state_nxt = S_ERR1;
        end
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
    ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_RESP) || (state_nxt == S_ERR2);
    resp_nxt  = (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
    en_nxt    = (state_nxt == S_ACCESS);
  end

  // State and registered bus/AHB outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      bus_en    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      HRDATA    <= '0;
    end else begin
      state     <= state_nxt;
      HREADYOUT <= ready_nxt;
      HRESP     <= resp_nxt;
      bus_en    <= en_nxt;
      if (capture) begin
        bus_addr <= 32'(HADDR);
        bus_we   <= HWRITE;
      end
      if (load_rdata) begin
        HRDATA <= XLEN'(bus_data_out);
      end
    end
  end

endmodule

// File: tb/tb_mpi_ahb3_slave_if.sv
// Self-checking bench for mpi_ahb3_slave_if: vector table, random transfers against a
// transaction-level model, and hand-written back-to-back / hang / reset sequences.
module tb_mpi_ahb3_slave_if;

  localparam int unsigned TO = 8;
`ifdef MPI_AHB3_TIMEOUT_EN
  localparam bit TO_EN    = 1'b1;
  localparam int HANG_CYC = 5;
`else
  localparam bit TO_EN    = 1'b0;
  localparam int HANG_CYC = 20;
`endif

  logic        clk, rst;
  logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP, HMASTLOCK;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] bus_addr, bus_data_in, bus_data_out;
  logic        bus_we, bus_en, bus_ack, bus_err;

  logic        hready_block, stray_ack, buf_err;
  int          buf_delay, en_cnt;
  logic [31:0] buf_data, exp_rd;
  int          checks, errors;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          delay;
    logic        err;
    logic [31:0] rdata;
    int          exp_waits;
    logic        exp_resp;
    int          exp_en;
    logic [31:0] exp_hrdata;
  } xfer_t;

  xfer_t tbl[7];

  mpi_ahb3_slave_if #(.PLEN(32), .XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-slave system: the bus ready is this slave's ready unless another slave stalls it.
  assign HREADY = HREADYOUT & ~hready_block;

  // Buffer model: responds in the (buf_delay+1)-th consecutive enabled cycle.
  always @(posedge clk) en_cnt <= (bus_en === 1'b1) ? en_cnt + 1 : 0;
  assign bus_ack      = stray_ack | (bus_en && !buf_err && en_cnt == buf_delay);
  assign bus_err      = bus_en && buf_err && en_cnt == buf_delay;
  assign bus_data_out = buf_data ^ bus_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: waits = cycles with HREADYOUT low in the data phase.
  function automatic xfer_t predict(input xfer_t t, input logic [31:0] last);
    xfer_t r = t;
    r.exp_hrdata = last;
    if (t.size != 3'b010 || t.addr[1:0] != 2'b00) begin
      r.exp_waits = 1; r.exp_resp = 1'b1; r.exp_en = 0;
    end else if (TO_EN && t.delay >= int'(TO)) begin
      r.exp_waits = int'(TO) + 1; r.exp_resp = 1'b1; r.exp_en = int'(TO);
    end else if (t.err) begin
      r.exp_waits = t.delay + 2; r.exp_resp = 1'b1; r.exp_en = t.delay + 1;
    end else begin
      r.exp_waits = t.delay + 1; r.exp_resp = 1'b0; r.exp_en = t.delay + 1;
      if (!t.wr) r.exp_hrdata = t.rdata;
    end
    return r;
  endfunction

  task automatic run(input xfer_t t, input string tag);
    int   waits, en_cyc;
    logic resp;
    bit   seen, done;
    buf_delay = t.delay; buf_err = t.err; buf_data = t.rdata ^ t.addr;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = t.addr; HWRITE = t.wr; HSIZE = t.size;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = t.wdata;
    waits = 0; en_cyc = 0; seen = 1'b0; done = 1'b0; resp = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus_en) begin
        en_cyc++;
        if (!seen) begin
          seen = 1'b1;
          check({tag, "_addr"}, bus_addr, t.addr);
          check({tag, "_we"}, 32'(bus_we), 32'(t.wr));
          if (t.wr) check({tag, "_wdata"}, bus_data_in, t.wdata);
        end
      end
      if (HREADYOUT) begin
        done = 1'b1;
        resp = HRESP;
      end else begin
        waits++;
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_waits"}, 32'(waits), 32'(t.exp_waits));
    check({tag, "_resp"}, 32'(resp), 32'(t.exp_resp));
    check({tag, "_en"}, 32'(en_cyc), 32'(t.exp_en));
    check({tag, "_hrdata"}, HRDATA, t.exp_hrdata);
    exp_rd = t.exp_hrdata;
    @(posedge clk); #1;
  endtask

  initial begin
    xfer_t t;
    int    n_low, n_en;
    checks = 0; errors = 0; exp_rd = 32'h0;
    rst = 1'b0; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HSIZE = 3'b010;
    HBURST = 3'b000; HPROT = 4'h3; HTRANS = 2'b00; HMASTLOCK = 1'b0;
    hready_block = 1'b0; stray_ack = 1'b0; buf_err = 1'b0; buf_delay = 0; buf_data = '0;

    //            wr    addr          size    wdata         dly err   rdata         wt rsp   en hrdata
    tbl[0] = '{1'b0, 32'h0000_0000, 3'b010, 32'h0,         0, 1'b0, 32'h0000_0001, 1, 1'b0, 1, 32'h0000_0001};
    tbl[1] = '{1'b1, 32'h0000_2000, 3'b010, 32'hDEAD_BEEF, 2, 1'b0, 32'h1111_1111, 3, 1'b0, 3, 32'h0000_0001};
    tbl[2] = '{1'b1, 32'h0000_0000, 3'b010, 32'h0BAD_F00D, 0, 1'b1, 32'h2222_2222, 2, 1'b1, 1, 32'h0000_0001};
    tbl[3] = '{1'b0, 32'h0000_0010, 3'b000, 32'h0,         0, 1'b0, 32'h3333_3333, 1, 1'b1, 0, 32'h0000_0001};
    tbl[4] = '{1'b0, 32'h0000_2002, 3'b010, 32'h0,         0, 1'b0, 32'h4444_4444, 1, 1'b1, 0, 32'h0000_0001};
    tbl[5] = '{1'b0, 32'h0000_0044, 3'b010, 32'h0,         4, 1'b0, 32'hCAFE_F00D, 5, 1'b0, 5, 32'hCAFE_F00D};
    tbl[6] = '{1'b0, 32'h0000_0008, 3'b010, 32'h0,         2, 1'b1, 32'h5555_5555, 4, 1'b1, 3, 32'hCAFE_F00D};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_bus_en", 32'(bus_en), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // BUSY, HREADY-stalled NONSEQ and stray ack in IDLE must all be ignored.
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h40; HSIZE = 3'b010;
    @(posedge clk);
    @(negedge clk);
    check("busy_ready", 32'(HREADYOUT), 32'd1);
    check("busy_en", 32'(bus_en), 32'd0);
    check("busy_resp", 32'(HRESP), 32'd0);
    @(posedge clk); #1;
    HTRANS = 2'b10; hready_block = 1'b1;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; hready_block = 1'b0; stray_ack = 1'b1; buf_data = 32'hBAD0_BAD0;
    @(negedge clk);
    check("nohready_en", 32'(bus_en), 32'd0);
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_hrdata", HRDATA, exp_rd);
    check("stray_ack_ready", 32'(HREADYOUT), 32'd1);
    @(posedge clk); #1;

    // Back-to-back reads: second phase is taken in RESP with no idle cycle.
    buf_delay = 0; buf_err = 1'b0; buf_data = 32'h1234_0000;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = 32'h100;
    @(posedge clk); #1;
    HADDR = 32'h104;
    @(negedge clk);
    check("b2b_a_en", 32'(bus_en), 32'd1);
    check("b2b_a_addr", bus_addr, 32'h100);
    @(negedge clk);
    check("b2b_a_ready", 32'(HREADYOUT), 32'd1);
    check("b2b_a_hrdata", HRDATA, 32'h1234_0100);
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge clk);
    check("b2b_b_en", 32'(bus_en), 32'd1);
    check("b2b_b_addr", bus_addr, 32'h104);
    @(negedge clk);
    check("b2b_b_ready", 32'(HREADYOUT), 32'd1);
    check("b2b_b_hrdata", HRDATA, 32'h1234_0104);
    exp_rd = 32'h1234_0104;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      t.wr    = 1'($urandom_range(0, 1));
      t.addr  = 32'($urandom_range(0, 32'hFFFF));
      if ($urandom_range(0, 7) != 0) t.addr[1:0] = 2'b00;
      t.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      t.wdata = $urandom;
      t.delay = int'($urandom_range(0, 4));
      t.err   = ($urandom_range(0, 5) == 0);
      t.rdata = $urandom;
      run(predict(t, exp_rd), $sformatf("rnd%0d", i));
    end

`ifdef MPI_AHB3_TIMEOUT_EN
    t = '{1'b0, 32'h200, 3'b010, 32'h0, 1000, 1'b0, 32'h6666_6666, 0, 1'b0, 0, 32'h0};
    run(predict(t, exp_rd), "timeout");
`endif

    // Buffer never answers; then reset lands mid-access.
    buf_delay = 1000; buf_err = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = 32'h300;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    n_low = 0; n_en = 0;
    for (int i = 0; i < HANG_CYC; i++) begin
      @(negedge clk);
      if (!HREADYOUT) n_low++;
      if (bus_en) n_en++;
    end
    check("hang_low", 32'(n_low), 32'(HANG_CYC));
    check("hang_en", 32'(n_en), 32'(HANG_CYC));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", 32'(HREADYOUT), 32'd1);
    check("midrst_en", 32'(bus_en), 32'd0);
    check("midrst_resp", 32'(HRESP), 32'd0);
    check("midrst_hrdata", HRDATA, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_rd = 32'h0;
    @(posedge clk); #1;
    t = '{1'b0, 32'h10, 3'b010, 32'h0, 1, 1'b0, 32'h0000_0077, 0, 1'b0, 0, 32'h0};
    run(predict(t, exp_rd), "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
